// File: rtl/bomberman_collision_if.sv
// Request/result and tile-map read signals shared between the collision checker,
// its requester and the tile-map RAM.
interface bomberman_collision_if;
    logic        start;
    logic [9:0]  b_x;
    logic [9:0]  b_y;
    logic [10:0] map_addr;
    logic [1:0]  map_data;
    logic [3:0]  bomberman_blocked;
    logic        busy;
    logic        done;

    modport master (
        output start, b_x, b_y, map_data,
        input  map_addr, bomberman_blocked, busy, done
    );

    modport slave (
        input  start, b_x, b_y, map_data,
        output map_addr, bomberman_blocked, busy, done
    );
endinterface

// File: rtl/bomberman_collision.sv
// Probes the tile map at the 8 pixels bordering the sprite and publishes a
// 4-bit blocked-direction vector once per check.
module bomberman_collision #(
    parameter int MAX_X    = 640,
    parameter int MAX_Y    = 480,
    parameter int MIN_Y    = 16,
    parameter int TILE     = 16,
    parameter int MAP_COLS = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    bomberman_collision_if.slave  bus
);

    localparam int SHIFT = $clog2(TILE);
    localparam logic signed [11:0] MAX_X_S = 12'(MAX_X);
    localparam logic signed [11:0] MAX_Y_S = 12'(MAX_Y);
    localparam logic signed [11:0] MIN_Y_S = 12'(MIN_Y);
    localparam logic signed [11:0] EDGE_S  = 12'(TILE);
    localparam logic signed [11:0] LAST_S  = 12'(TILE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t       state;
    logic [9:0]   bx;
    logic [9:0]   by;
    logic [2:0]   probe_idx;
    logic         drain_cnt;
    logic         s1_valid;
    logic         s1_oor;
    logic [1:0]   s1_bit;
    logic         s2_valid;
    logic         s2_oor;
    logic [1:0]   s2_bit;
    logic [3:0]   acc;
    logic [3:0]   acc_next;

    logic signed [11:0] bx_s;
    logic signed [11:0] by_s;
    logic signed [11:0] px;
    logic signed [11:0] py;
    logic               oor;
    logic [11:0]        ydiff;
    logic [11:0]        row;
    logic [11:0]        col;
    logic [11:0]        addr_full;

    // Coordinates carry a spare bit so bx+16 near the 10-bit limit cannot wrap.
    always_comb begin
        bx_s = {2'b00, bx};
        by_s = {2'b00, by};
        px   = bx_s;
        py   = by_s;
        case (probe_idx)
            3'd0: begin px = bx_s - 12'sd1;  py = by_s;          end
            3'd1: begin px = bx_s - 12'sd1;  py = by_s + LAST_S; end
            3'd2: begin px = bx_s + EDGE_S;  py = by_s;          end
            3'd3: begin px = bx_s + EDGE_S;  py = by_s + LAST_S; end
            3'd4: begin px = bx_s;           py = by_s + EDGE_S; end
            3'd5: begin px = bx_s + LAST_S;  py = by_s + EDGE_S; end
            3'd6: begin px = bx_s;           py = by_s - 12'sd1; end
            default: begin px = bx_s + LAST_S; py = by_s - 12'sd1; end
        endcase
        oor       = (px < 12'sd0) || (px >= MAX_X_S) || (py < MIN_Y_S) || (py >= MAX_Y_S);
        ydiff     = py - MIN_Y_S;
        row       = ydiff >> SHIFT;
        col       = px >> SHIFT;
        addr_full = (row << 5) + (row << 3) + col;
    end

    always_comb begin
        acc_next = acc;
        if (s2_valid && (s2_oor || (bus.map_data != 2'b00))) begin
            acc_next[s2_bit] = 1'b1;
        end
    end

    // Probe info travels two stages to line up with the RAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            bx                    <= '0;
            by                    <= '0;
            probe_idx             <= '0;
            drain_cnt             <= 1'b0;
            s1_valid              <= 1'b0;
            s1_oor                <= 1'b0;
            s1_bit                <= '0;
            s2_valid              <= 1'b0;
            s2_oor                <= 1'b0;
            s2_bit                <= '0;
            acc                   <= '0;
            bus.map_addr          <= '0;
            bus.bomberman_blocked <= 4'b1111;
            bus.busy              <= 1'b0;
            bus.done              <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            s1_valid <= 1'b0;
            s2_valid <= s1_valid;
            s2_oor   <= s1_oor;
            s2_bit   <= s1_bit;
            acc      <= acc_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bx        <= bus.b_x;
                        by        <= bus.b_y;
                        probe_idx <= '0;
                        acc       <= '0;
                        bus.busy  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.map_addr <= oor ? 11'd0 : addr_full[10:0];
                    s1_valid     <= 1'b1;
                    s1_oor       <= oor;
                    s1_bit       <= 2'd3 - probe_idx[2:1];
                    probe_idx    <= probe_idx + 3'd1;
                    if (probe_idx == 3'd7) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        bus.bomberman_blocked <= acc_next;
                        bus.done              <= 1'b1;
                        bus.busy              <= 1'b0;
                        state                 <= IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bomberman_collision.sv
// Directed checks of bomberman_collision against a registered-read tile-map model
// with hand-computed probe addresses and blocked vectors.
module tb_bomberman_collision;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;
    int   exp_addr [8];
    int   done_seen;

    logic [1:0] tile_mem [0:2047];

    always #5 clk = ~clk;

    bomberman_collision_if bif();

    bomberman_collision dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always @(posedge clk) bif.map_data <= tile_mem[bif.map_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
        bif.b_x   = x;
        bif.b_y   = y;
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
    endtask

    // Runs one full check; the hazard variant moves b_x before E3 and re-pulses start at E4.
    task automatic runCheck(input string name, input logic [9:0] x, input logic [9:0] y,
                            input logic [3:0] prev, input logic [3:0] expected, input bit hazard);
        applyStimulus(x, y);
        checkOutput({name, " busy@E0"}, 32'(bif.busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("%s addr%0d", name, k), 32'(bif.map_addr), 32'(exp_addr[k]));
            checkOutput($sformatf("%s hold%0d", name, k), 32'(bif.bomberman_blocked), 32'(prev));
            if (hazard && k == 1) bif.b_x = 10'd0;
            if (hazard && k == 2) bif.start = 1'b1;
            if (hazard && k == 3) bif.start = 1'b0;
        end
        tick();
        checkOutput({name, " done@E9"}, 32'(bif.done), 32'd0);
        checkOutput({name, " hold@E9"}, 32'(bif.bomberman_blocked), 32'(prev));
        tick();
        checkOutput({name, " done@E10"}, 32'(bif.done), 32'd1);
        checkOutput({name, " busy@E10"}, 32'(bif.busy), 32'd0);
        checkOutput({name, " blocked"}, 32'(bif.bomberman_blocked), 32'(expected));
        tick();
        checkOutput({name, " done@E11"}, 32'(bif.done), 32'd0);
        checkOutput({name, " busy@E11"}, 32'(bif.busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) tile_mem[i] = 2'b00;
        reset     = 1'b1;
        bif.start = 1'b0;
        bif.b_x   = '0;
        bif.b_y   = '0;
        tick();
        tick();
        checkOutput("rst blocked", 32'(bif.bomberman_blocked), 32'hF);
        checkOutput("rst busy", 32'(bif.busy), 32'd0);
        checkOutput("rst done", 32'(bif.done), 32'd0);
        checkOutput("rst addr", 32'(bif.map_addr), 32'd0);
        reset = 1'b0;
        tick();

        exp_addr = '{206, 246, 207, 247, 246, 247, 206, 207};
        runCheck("floor100", 10'd100, 10'd100, 4'b1111, 4'b0000, 1'b0);

        exp_addr = '{0, 0, 1, 1, 40, 40, 0, 0};
        runCheck("topleft", 10'd0, 10'd16, 4'b0000, 4'b1001, 1'b0);

        exp_addr = '{1158, 1158, 0, 0, 0, 0, 1119, 1119};
        runCheck("botright", 10'd624, 10'd464, 4'b1001, 4'b0110, 1'b0);

        tile_mem[208] = 2'b01;
        exp_addr = '{206, 246, 208, 248, 247, 247, 207, 207};
        runCheck("tileR", 10'd112, 10'd100, 4'b0110, 4'b0100, 1'b0);

        exp_addr = '{246, 246, 248, 248, 287, 287, 207, 207};
        runCheck("hazard", 10'd112, 10'd112, 4'b0100, 4'b0000, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bif.done) done_seen++;
        end
        checkOutput("hazard extra done", 32'(done_seen), 32'd0);

        applyStimulus(10'd100, 10'd100);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        checkOutput("abort blocked", 32'(bif.bomberman_blocked), 32'hF);
        checkOutput("abort busy", 32'(bif.busy), 32'd0);
        checkOutput("abort done", 32'(bif.done), 32'd0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bif.done) done_seen++;
        end
        checkOutput("abort no done", 32'(done_seen), 32'd0);

        tile_mem[206] = 2'b10;
        exp_addr = '{206, 246, 207, 247, 246, 247, 206, 207};
        runCheck("restart", 10'd100, 10'd100, 4'b1111, 4'b1001, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
